str_scan_sequencer: RTL and testbench
=====================================

// Module: str_scan_sequencer
// PURPOSE
//  Sequences a byte-stream string matcher (the dfa block: clk/reset/data[7:0] in, result out) across a buffer of
//  NUL-terminated strings held in a byte RAM. Streams one byte per cycle, checks the matcher verdict at each NUL,
//  and counts scanned and matching strings. Sits between the host command interface and the matcher instance.
// PARAMETERS
//  ADDR_W  8  byte-RAM address width
//  CNT_W   8  width of str_count / match_count (saturating)
// PORTS
//  clk          in   1       clock, all logic on posedge
//  reset        in   1       synchronous, active-high
//  start        in   1       1-cycle pulse; ignored unless idle
//  start_addr   in   ADDR_W  first byte address (inclusive)
//  end_addr     in   ADDR_W  last byte address (inclusive)
//  busy         out  1       high from cycle after accepted start until done
//  done         out  1       1-cycle pulse, counts valid
//  str_count    out  CNT_W   non-empty strings scanned
//  match_count  out  CNT_W   strings where matcher result==1 at terminator
//  mem_rd       out  1       RAM read strobe
//  mem_addr     out  ADDR_W  RAM read address
//  mem_rdata    in   8       RAM data, valid exactly 1 cycle after mem_rd
//  m_reset      out  1       drives matcher reset
//  m_data       out  8       drives matcher data
//  m_result     in   1       matcher result (combinational from its state)
// BEHAVIOUR
//  Reset: busy=0, done=0, str_count=0, match_count=0, mem_rd=0, mem_addr=0, m_reset=1, m_data=8'h00, FSM=IDLE.
//  Matcher has no enable and advances every clock: the byte stream within a scan has no gaps.
//  FSM: IDLE -> RUN -> [PAD] -> CHECK -> DONE -> IDLE.
//   IDLE: m_reset=1. start with start_addr<=end_addr: clear counts, latch addrs, -> RUN.
//         start with start_addr>end_addr: no reads, counts cleared, done pulses next cycle, -> IDLE.
//   RUN: mem_rd=1 every cycle, mem_addr = start_addr .. end_addr (+1/cycle, N=end-start+1 reads, no wrap).
//        m_reset=0 from first data cycle; m_data = mem_rdata while data stage valid (1-cycle pipe).
//   Per fed byte: non-NUL sets nonempty flag. NUL with nonempty=1 -> next cycle sample m_result:
//        str_count+=1, match_count+=m_result; nonempty cleared. NUL with nonempty=0 (empty string) -> ignored.
//   Last byte fed non-NUL: PAD presents one synthetic 8'h00 (same sampling rule). Last byte NUL: skip PAD.
//   CHECK: final sample cycle. DONE: done=1 for one cycle, busy=0, m_reset=1, -> IDLE.
//  Latency (start sampled cycle 0): done at cycle N+3 if last byte NUL, N+4 if PAD used.
//  Counts saturate at 2^CNT_W-1, no wrap. Counts held after done until next accepted start.
//  start while busy: ignored, no effect on counts/addresses. start coincident with done: ignored.
//  reset mid-scan: immediate return to reset values; in-flight read data discarded; no done pulse.
//  end_addr = 2^ADDR_W-1: mem_addr stops at end_addr, no wrap to 0.
// CONFIGURATION
//  FIRST_MATCH_EN defined: adds outputs first_match_vld (1) and first_match_addr (ADDR_W): start address of first
//   matching string of the scan; cleared on accepted start and reset; valid with done, held afterwards.
//  FIRST_MATCH_EN undefined: those ports and the per-string start-address register are absent; other behaviour identical.
// TESTING (byte RAM model, 1-cycle read, real dfa matcher attached)
//  RAM "n\0ab\0" at 0x10..0x14, start 0x10..0x14 -> str_count=2, match_count=1, done at cycle 8, no PAD.
//  RAM "n" at 0x20 only, range 0x20..0x20 -> PAD fed, str=1, match=1, done at cycle 5.
//  RAM "\0\0n\0", range 0..3 -> empties skipped: str=1, match=1; mem_rd high exactly 4 cycles.
//  start_addr=0x05, end_addr=0x04 -> no mem_rd, done at cycle 1, counts 0; start during busy -> ignored.
//  300 strings "n\0" with CNT_W=8 -> str_count=match_count=255 (saturated); FIRST_MATCH_EN: first_match_addr=start_addr.
//  reset asserted mid-RUN -> next cycle busy=0, m_reset=1, counts 0, no done; fresh start scans correctly.

Source files
------------

// File: rtl/str_scan_sequencer.sv
// rtl/str_scan_sequencer.sv - streams NUL-terminated strings from byte RAM through a matcher and counts hits
// Optional FIRST_MATCH_EN adds first_match_vld/first_match_addr (start address of first matching string).
module str_scan_sequencer #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  str_count,
    output logic [CNT_W-1:0]  match_count,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              m_reset,
    output logic [7:0]        m_data,
    input  logic              m_result
`ifdef FIRST_MATCH_EN
    ,
    output logic              first_match_vld,
    output logic [ADDR_W-1:0] first_match_addr
`endif
);

    typedef enum logic [2:0] {IDLE, RUN, PAD, CHECK, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] end_q;
    logic              rd_active, dvalid, dlast, nonempty, pend;
    logic              accept, empty_req, feed, fed_nul;

    assign accept    = (state == IDLE) && start && (start_addr <= end_addr);
    assign empty_req = (state == IDLE) && start && (start_addr > end_addr);
    // PAD injects a synthetic terminator so an unterminated final string still gets judged
    assign feed      = dvalid || (state == PAD);
    assign m_data    = dvalid ? mem_rdata : 8'h00;
    assign fed_nul   = (m_data == 8'h00);
    assign mem_rd    = rd_active;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = RUN;
                     else if (empty_req) state_nx = DONE;
            RUN:     if (dvalid && dlast) state_nx = fed_nul ? CHECK : PAD;
            PAD:     state_nx = CHECK;
            CHECK:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state == RUN) || (state == PAD) || (state == CHECK);
        done    = (state == DONE);
        m_reset = !(dvalid || (state == PAD) || (state == CHECK));
    end

    // Read issue, 1-cycle data pipe, and terminator sampling one cycle after the NUL is clocked in
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_active   <= 1'b0;
            mem_addr    <= '0;
            end_q       <= '0;
            dvalid      <= 1'b0;
            dlast       <= 1'b0;
            nonempty    <= 1'b0;
            pend        <= 1'b0;
            str_count   <= '0;
            match_count <= '0;
        end else begin
            dvalid <= rd_active;
            dlast  <= rd_active && (mem_addr == end_q);
            if (accept) begin
                rd_active <= 1'b1;
                mem_addr  <= start_addr;
                end_q     <= end_addr;
            end else if (rd_active) begin
                if (mem_addr == end_q) rd_active <= 1'b0;
                else                   mem_addr  <= mem_addr + ADDR_W'(1);
            end
            if (accept)    nonempty <= 1'b0;
            else if (feed) nonempty <= !fed_nul;
            pend <= feed && fed_nul && nonempty;
            if (accept || empty_req) begin
                str_count   <= '0;
                match_count <= '0;
            end else if (pend) begin
                if (str_count != CNT_MAX) str_count <= str_count + CNT_W'(1);
                if (m_result && match_count != CNT_MAX) match_count <= match_count + CNT_W'(1);
            end
        end
    end

`ifdef FIRST_MATCH_EN
    logic [ADDR_W-1:0] daddr, str_start;

    always_ff @(posedge clk) begin
        if (reset) begin
            daddr            <= '0;
            str_start        <= '0;
            first_match_vld  <= 1'b0;
            first_match_addr <= '0;
        end else begin
            daddr <= mem_addr;
            if (feed && !fed_nul && !nonempty) str_start <= daddr;
            if (accept || empty_req) begin
                first_match_vld  <= 1'b0;
                first_match_addr <= '0;
            end else if (pend && m_result && !first_match_vld) begin
                first_match_vld  <= 1'b1;
                first_match_addr <= str_start;
            end
        end
    end
`endif

endmodule

// File: tb/tb_str_scan_sequencer.sv
// tb/tb_str_scan_sequencer.sv - bench for str_scan_sequencer with byte RAM and a "contains 'n'" matcher
module tb_str_scan_sequencer;
    localparam int AW = 10;
    localparam int CW = 8;
    localparam logic [7:0] CH_N = 8'h6e;

    logic          clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [AW-1:0] start_addr = '0, end_addr = '0;
    logic          busy, done, mem_rd, m_reset, m_result;
    logic [CW-1:0] str_count, match_count;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata = 8'h00, m_data;
`ifdef FIRST_MATCH_EN
    logic          first_match_vld;
    logic [AW-1:0] first_match_addr;
`endif

    str_scan_sequencer #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .end_addr(end_addr),
        .busy(busy), .done(done), .str_count(str_count), .match_count(match_count),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .m_reset(m_reset), .m_data(m_data), .m_result(m_result)
`ifdef FIRST_MATCH_EN
        , .first_match_vld(first_match_vld), .first_match_addr(first_match_addr)
`endif
    );

    logic [7:0] ram [0:1023];
    logic       m_cur = 1'b0, m_res = 1'b0;
    int cyc = 0, n_cmp = 0, n_fail = 0;

    // expectations, written only by the driver
    bit has_scan = 1'b0, exp_fvld = 1'b0;
    int t0 = 0, exp_s = 0, exp_n = 0, exp_done_k = 0, exp_str = 0, exp_match = 0, exp_faddr = 0;
    int lit_str = 0, lit_match = 0, lit_done = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mem_rd) mem_rdata <= ram[mem_addr];

    // matcher: result = last terminated string contained 'n'
    always @(posedge clk) begin
        if (m_reset) begin
            m_cur <= 1'b0;
            m_res <= 1'b0;
        end else if (m_data == 8'h00) begin
            m_res <= m_cur;
            m_cur <= 1'b0;
        end else begin
            m_cur <= m_cur | (m_data == CH_N);
        end
    end
    assign m_result = m_res;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        int k;
        if (!reset) begin
            k = has_scan ? cyc - t0 : -1;
            if (has_scan && k >= 1 && k <= exp_done_k) begin
                chk("mem_rd", mem_rd, int'(k <= exp_n));
                if (k <= exp_n) chk("mem_addr", mem_addr, exp_s + k - 1);
                chk("busy", busy, int'(k < exp_done_k));
                chk("done", done, int'(k == exp_done_k));
                chk("m_reset", m_reset, int'(!(k >= 2 && k < exp_done_k)));
                if (k >= 2 && k <= exp_n + 1) chk("m_data", m_data, ram[exp_s + k - 2]);
                else if (k == exp_n + 2 && k < exp_done_k) chk("m_data_pad", m_data, 0);
                if (k == exp_done_k) begin
                    chk("str_count", str_count, exp_str);
                    chk("match_count", match_count, exp_match);
                    chk("model_str", exp_str, lit_str);
                    chk("model_match", exp_match, lit_match);
                    chk("model_done_cycle", exp_done_k, lit_done);
`ifdef FIRST_MATCH_EN
                    chk("first_match_vld", first_match_vld, int'(exp_fvld));
                    if (exp_fvld) chk("first_match_addr", first_match_addr, exp_faddr);
`endif
                end
            end else begin
                chk("busy_idle", busy, 0);
                chk("done_idle", done, 0);
                chk("mem_rd_idle", mem_rd, 0);
                chk("m_reset_idle", m_reset, 1);
                if (!(has_scan && k == 0)) begin
                    chk("str_count_held", str_count, exp_str);
                    chk("match_count_held", match_count, exp_match);
                end
            end
        end
    end

    // Split the range into strings and judge each independently
    task automatic model(input int s, input int e);
        bit ne = 1'b0, hasn = 1'b0;
        int cur = 0;
        logic [7:0] b;
        exp_str = 0; exp_match = 0; exp_fvld = 1'b0; exp_faddr = 0; exp_s = s;
        if (s > e) begin
            exp_n = 0;
            exp_done_k = 1;
            return;
        end
        exp_n = e - s + 1;
        for (int a = s; a <= e + 1; a++) begin
            b = (a <= e) ? ram[a] : 8'h00;
            if (b != 8'h00) begin
                if (!ne) begin ne = 1'b1; hasn = 1'b0; cur = a; end
                if (b == CH_N) hasn = 1'b1;
            end else if (ne) begin
                ne = 1'b0;
                if (exp_str < 255) exp_str++;
                if (hasn) begin
                    if (exp_match < 255) exp_match++;
                    if (!exp_fvld) begin exp_fvld = 1'b1; exp_faddr = cur; end
                end
            end
        end
        exp_done_k = exp_n + 3 + int'(ram[e] != 8'h00);
    endtask

    task automatic run_scan(input int s, input int e, input int ls, input int lm, input int ld,
                            input int busy_k, input bit coincide);
        @(posedge clk); #2;
        model(s, e);
        lit_str = ls; lit_match = lm; lit_done = ld;
        t0 = cyc; has_scan = 1'b1;
        start = 1'b1; start_addr = AW'(s); end_addr = AW'(e);
        for (int j = 1; j <= exp_done_k + 2; j++) begin
            @(posedge clk); #2;
            start = 1'b0;
            if (j == busy_k) begin start = 1'b1; start_addr = 10'h3f0; end_addr = 10'h3f8; end
            if (coincide && j == exp_done_k) start = 1'b1;
        end
    endtask

    task automatic load_t1();
        ram[16] = CH_N; ram[17] = 8'h00; ram[18] = 8'h61; ram[19] = 8'h62; ram[20] = 8'h00;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'h2e;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);

        load_t1();
        run_scan(16, 20, 2, 1, 8, 0, 1'b0);
        ram[32] = CH_N;
        run_scan(32, 32, 1, 1, 5, 0, 1'b1);
        ram[0] = 8'h00; ram[1] = 8'h00; ram[2] = CH_N; ram[3] = 8'h00;
        run_scan(0, 3, 1, 1, 7, 2, 1'b0);
        run_scan(5, 4, 0, 0, 1, 0, 1'b0);
        ram[1020] = 8'h78; ram[1021] = CH_N; ram[1022] = 8'h00; ram[1023] = 8'h79;
        run_scan(1020, 1023, 2, 1, 8, 0, 1'b0);

        // abort mid-RUN, then a fresh scan
        @(posedge clk); #2;
        model(16, 20);
        t0 = cyc; has_scan = 1'b1;
        start = 1'b1; start_addr = AW'(16); end_addr = AW'(20);
        repeat (3) begin @(posedge clk); #2; start = 1'b0; end
        reset = 1'b1;
        has_scan = 1'b0; exp_str = 0; exp_match = 0; exp_fvld = 1'b0;
        @(posedge clk); #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        run_scan(16, 20, 2, 1, 8, 0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            ram[4 + 2 * i] = CH_N;
            ram[5 + 2 * i] = 8'h00;
        end
        run_scan(4, 603, 255, 255, 603, 0, 1'b0);

        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
